// File: rtl/tnn_pkg.sv
// Shared helpers and beat record for the TNN sum-and-compare datapath.
package tnn_pkg;

  // Storage width for a group sum inside the S1 beat record; group sums must fit.
  localparam int SUM_MAX_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Signed accumulator width: covers MAX_BEATS beats of the larger group sum, plus sign.
  function automatic int acc_w(input int w, input int np, input int nn, input int mb);
    int m;
    m = (np > nn) ? np : nn;
    return clog2(m * ((1 << w) - 1) * mb + 1) + 1;
  endfunction

  typedef struct packed {
    logic [SUM_MAX_W-1:0] sum_pos;
    logic [SUM_MAX_W-1:0] sum_neg;
    logic                 last;
  } beat_t;

endpackage

// File: rtl/tnn_sum_tree.sv
// Combinational unsigned sum of N packed W-bit operands.
module tnn_sum_tree
  import tnn_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 3,
  localparam int OW = W + clog2(N)
) (
  input  logic [N*W-1:0] ops,
  output logic [OW-1:0]  sum
);

  // Zero-extend each operand and add; OW is wide enough that nothing wraps.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + OW'(ops[k*W +: W]);
  end

endmodule

// File: rtl/tnn_sumcmp_stream.sv
// Pipelined sum-and-compare neuron: per-beat group difference accumulated over a frame,
// one thresholded decision per frame on a valid/ready output.
module tnn_sumcmp_stream
  import tnn_pkg::*;
#(
  parameter int  W         = 3,
  parameter int  N_POS     = 3,
  parameter int  N_NEG     = 2,
  parameter int  MAX_BEATS = 4,
  parameter int  THRESH    = 0,
  localparam int ACC_W     = acc_w(W, N_POS, N_NEG, MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_POS*W-1:0]      in_pos,
  input  logic [N_NEG*W-1:0]      in_neg,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic signed [ACC_W-1:0] out_margin,
  output logic                    out_trunc
);

  localparam int PW    = W + clog2(N_POS);
  localparam int NW    = W + clog2(N_NEG);
  localparam int CNT_W = clog2(MAX_BEATS + 1);
  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESH);

  logic [PW-1:0]             sum_pos;
  logic [NW-1:0]             sum_neg;
  beat_t                     beat_in, s1;
  logic                      s1_vld;
  logic signed [ACC_W-1:0]   acc, diff, acc_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      first, hit, close, en;

  tnn_sum_tree #(.N(N_POS), .W(W)) u_pos (.ops(in_pos), .sum(sum_pos));
  tnn_sum_tree #(.N(N_NEG), .W(W)) u_neg (.ops(in_neg), .sum(sum_neg));

  // Whole pipeline advances only when the output slot is free or being drained.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_comb begin
    beat_in.sum_pos = SUM_MAX_W'(sum_pos);
    beat_in.sum_neg = SUM_MAX_W'(sum_neg);
    beat_in.last    = in_last;
  end

  // Accumulate the S1 beat and decide whether it closes the frame.
  always_comb begin
    diff    = $signed(ACC_W'(s1.sum_pos)) - $signed(ACC_W'(s1.sum_neg));
    acc_nxt = (first ? '0 : acc) + diff;
    cnt_nxt = cnt + 1'b1;
    hit     = (cnt_nxt == CNT_W'(MAX_BEATS));
    close   = s1_vld & (s1.last | hit);
  end

  // S1: register the group sums of the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else if (en) begin
      s1_vld <= in_valid;
      if (in_valid) s1 <= beat_in;
    end
  end

  // S2: frame accumulator and beat counter; a close restarts the frame with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b1;
    end else if (en && s1_vld) begin
      acc <= acc_nxt;
      if (close) begin
        cnt   <= '0;
        first <= 1'b1;
      end else begin
        cnt   <= cnt_nxt;
        first <= 1'b0;
      end
    end
  end

  // Output register: loads on close, otherwise holds until the handshake frees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      out_margin <= '0;
      out_trunc  <= 1'b0;
    end else if (en) begin
      out_valid <= close;
      if (close) begin
        out_bit    <= (acc_nxt > THR);
        out_margin <= acc_nxt;
        out_trunc  <= hit & ~s1.last;
      end
    end
  end

endmodule

// File: tb/tb_tnn_sumcmp_stream.sv
// Scoreboard bench for tnn_sumcmp_stream: directed frames plus randomized traffic.
module tb_tnn_sumcmp_stream;
  localparam int W = 3, N_POS = 3, N_NEG = 2, MAX_BEATS = 4, THRESH = 0;
  localparam int ACC_W = 8;
  localparam int PW = N_POS * W, NW = N_NEG * W;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [PW-1:0] in_pos = '0;
  logic [NW-1:0] in_neg = '0;
  logic out_valid, out_ready = 1, out_bit, out_trunc;
  logic signed [ACC_W-1:0] out_margin;

  tnn_sumcmp_stream #(.W(W), .N_POS(N_POS), .N_NEG(N_NEG), .MAX_BEATS(MAX_BEATS), .THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_margin(out_margin), .out_trunc(out_trunc));

  always #5 clk = ~clk;

  typedef struct { int ob; int margin; int trunc; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_acc = 0, m_cnt = 0;
  bit rnd_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame sum of (sum pos - sum neg), closed on last or MAX_BEATS beats.
  task automatic model_accept(input logic [PW-1:0] p, input logic [NW-1:0] n, input logic l);
    exp_t e;
    for (int k = 0; k < N_POS; k++) m_acc += int'(p[k*W +: W]);
    for (int k = 0; k < N_NEG; k++) m_acc -= int'(n[k*W +: W]);
    m_cnt++;
    if (l || m_cnt == MAX_BEATS) begin
      e.ob = (m_acc > THRESH) ? 1 : 0;
      e.margin = m_acc;
      e.trunc = (!l && m_cnt == MAX_BEATS) ? 1 : 0;
      q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Present a beat (called at posedge+1), hold until accepted, return at posedge+1.
  task automatic send_beat(input logic [PW-1:0] p, input logic [NW-1:0] n, input logic l);
    int waitc = 0;
    bit ok = 0;
    in_valid = 1; in_pos = p; in_neg = n; in_last = l;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      if (in_ready && rst_n) ok = 1; else waitc++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: beat not accepted within 200 cycles");
    end else model_accept(p, n, l);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
    chk("drain_queue_size", q.size(), 0);
  endtask

  // Monitor: pop/compare on every handshake, and require held outputs while stalled.
  bit hold = 0;
  int h_bit, h_margin, h_trunc;
  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_bit", int'(out_bit), h_bit);
        chk("stall_margin", int'(out_margin), h_margin);
        chk("stall_trunc", int'(out_trunc), h_trunc);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: margin %0d with no decision pending", out_margin);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_bit", int'(out_bit), e.ob);
          chk("out_margin", int'(out_margin), e.margin);
          chk("out_trunc", int'(out_trunc), e.trunc);
        end
      end
      hold = out_valid && !out_ready;
      h_bit = int'(out_bit); h_margin = int'(out_margin); h_trunc = int'(out_trunc);
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_margin", int'(out_margin), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Single beat 7+7+7 - 0, with two-cycle latency
    send_beat({3'd7, 3'd7, 3'd7}, {3'd0, 3'd0}, 1);
    @(negedge clk); chk("lat_t1_valid", int'(out_valid), 0);
    @(negedge clk); chk("lat_t2_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    drain();

    // Tie: 3 - 3 = 0 is not above threshold
    send_beat({3'd1, 3'd1, 3'd1}, {3'd1, 3'd2}, 1);
    drain();

    // Three-beat frame -4, +2, +3
    send_beat({3'd0, 3'd0, 3'd0}, {3'd0, 3'd4}, 0);
    send_beat({3'd0, 3'd0, 3'd2}, {3'd0, 3'd0}, 0);
    send_beat({3'd0, 3'd0, 3'd3}, {3'd0, 3'd0}, 1);
    drain();

    // Truncated frame: four beats of -1 without last, then a fresh frame
    repeat (4) send_beat({3'd0, 3'd0, 3'd0}, {3'd0, 3'd1}, 0);
    send_beat({3'd0, 3'd0, 3'd5}, {3'd0, 3'd0}, 1);
    drain();

    // Last on the MAX_BEATS-th beat is a normal close
    repeat (3) send_beat({3'd0, 3'd1, 3'd0}, {3'd0, 3'd0}, 0);
    send_beat({3'd0, 3'd1, 3'd0}, {3'd0, 3'd0}, 1);
    drain();

    // Backpressure: stall output while single-beat frames keep coming
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_beat(PW'(i * 37 + 5), NW'(i * 11 + 3), 1);
      end
      begin
        out_ready = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();

    // Reset mid-frame discards the partial frame
    send_beat({3'd0, 3'd0, 3'd6}, {3'd0, 3'd0}, 0);
    send_beat({3'd0, 3'd0, 3'd6}, {3'd0, 3'd0}, 0);
    rst_n = 0;
    m_acc = 0; m_cnt = 0; q.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_bit", int'(out_bit), 0);
    chk("midrst_out_margin", int'(out_margin), 0);
    chk("midrst_out_trunc", int'(out_trunc), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    send_beat({3'd0, 3'd0, 3'd3}, {3'd0, 3'd1}, 1);
    drain();

    // Randomized traffic with random bubbles and random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_beat(PW'($urandom), NW'($urandom), $urandom_range(0, 9) < 3);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1;
      end
    join
    // Close any open random frame so every beat produces a checked decision
    send_beat({3'd0, 3'd0, 3'd1}, {3'd0, 3'd0}, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
